// File: rtl/obi_sram_shim_if.sv
// OBI subordinate-side bus bundle between a crossbar manager port and the SRAM shim.
// The manager side drives requests and rready; the subordinate side returns grant and responses.
interface obi_sram_shim_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 8
);
    logic                   req;
    logic                   gnt;
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic [IdWidth-1:0]     aid;
    logic                   rvalid;
    logic                   rready;
    logic [DataWidth-1:0]   rdata;
    logic [IdWidth-1:0]     rid;
    logic                   err;

    modport master (
        output req, addr, we, be, wdata, aid, rready,
        input  gnt, rvalid, rdata, rid, err
    );

    modport slave (
        input  req, addr, we, be, wdata, aid, rready,
        output gnt, rvalid, rdata, rid, err
    );
endinterface

// File: rtl/obi_sram_shim.sv
// Terminates an OBI manager port onto a single-port SRAM: range check, fixed-latency
// tracking pipeline, in-order fall-through response FIFO and a credit limit on outstanding work.
module obi_sram_shim #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned IdWidth        = 8,
    parameter int unsigned MemAddrWidth   = 12,
    parameter int unsigned MemLatency     = 1,
    parameter int unsigned NumOutstanding = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    obi_sram_shim_if.slave          sbr,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic                    mem_we_o,
    output logic [MemAddrWidth-1:0] mem_addr_o,
    output logic [DataWidth/8-1:0]  mem_be_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    input  logic [DataWidth-1:0]    mem_rdata_i
);
    localparam int unsigned Off      = $clog2(DataWidth / 8);
    localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);
    localparam int unsigned PtrWidth = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;

    typedef logic [CntWidth-1:0] cnt_t;
    typedef logic [PtrWidth-1:0] ptr_t;

    typedef struct packed {
        logic                 valid;
        logic [IdWidth-1:0]   id;
        logic                 we;
        logic                 err;
    } stage_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   id;
        logic                 err;
    } rsp_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(NumOutstanding - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    cnt_t   cnt_q;
    cnt_t   fill_q;
    ptr_t   wr_ptr_q, rd_ptr_q;
    stage_t pipe_q [MemLatency];
    rsp_t   fifo_q [NumOutstanding];
    rsp_t   push_rsp, head;
    logic   avail, oor, accept, push, pop, fifo_empty, store;

    // Address bits above the macro's word range flag the access as out of range.
    if (AddrWidth > MemAddrWidth + Off) begin : g_oor
        assign oor = |sbr.addr[AddrWidth-1:MemAddrWidth+Off];
    end else begin : g_no_oor
        assign oor = 1'b0;
    end

    if (Off > 0) begin : g_byte_off
        logic unused_byte_off;
        assign unused_byte_off = ^sbr.addr[Off-1:0];
    end

    // Credit check uses only the registered count, so a same-cycle retire never frees a slot.
    assign avail       = (cnt_q < cnt_t'(NumOutstanding));
    assign mem_req_o   = sbr.req & avail & ~oor;
    assign sbr.gnt     = sbr.req & avail & (oor | mem_gnt_i);
    assign accept      = sbr.req & sbr.gnt;
    assign mem_we_o    = sbr.we;
    assign mem_addr_o  = sbr.addr[MemAddrWidth+Off-1:Off];
    assign mem_be_o    = sbr.be;
    assign mem_wdata_o = sbr.wdata;

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MemLatency; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= '{valid: accept, id: sbr.aid, we: sbr.we, err: oor};
            for (int i = 1; i < MemLatency; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign push           = pipe_q[MemLatency-1].valid;
    assign push_rsp.rdata = (pipe_q[MemLatency-1].we | pipe_q[MemLatency-1].err) ? '0 : mem_rdata_i;
    assign push_rsp.id    = pipe_q[MemLatency-1].id;
    assign push_rsp.err   = pipe_q[MemLatency-1].err;

    assign fifo_empty = (fill_q == '0);

    // NOTE: combinational blocks assign a default first so no path leaves head unassigned (no latch).
    always_comb begin
        head = '0;
        if (!fifo_empty) begin
            head = fifo_q[rd_ptr_q];
        end else if (push) begin
            head = push_rsp;
        end
    end

    assign sbr.rvalid = ~fifo_empty | push;
    assign sbr.rdata  = head.rdata;
    assign sbr.rid    = head.id;
    assign sbr.err    = head.err;
    assign pop        = sbr.rvalid & sbr.rready;
    // An entry consumed in its push cycle from an empty FIFO bypasses the storage.
    assign store      = push & ~(fifo_empty & pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q  <= cnt_q + cnt_t'(accept) - cnt_t'(pop);
            fill_q <= fill_q + cnt_t'(store) - cnt_t'(pop & ~fifo_empty);
            if (store)               wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop && !fifo_empty)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    // NOTE: the response storage has no reset; fill_q alone defines which entries are live.
    always_ff @(posedge clk_i) begin
        if (store) fifo_q[wr_ptr_q] <= push_rsp;
    end

    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        push |-> (fill_q != cnt_t'(NumOutstanding)));
    a_cnt_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= cnt_t'(NumOutstanding));
    a_rsp_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (sbr.rvalid && !sbr.rready) |=> (sbr.rvalid && $stable(sbr.rdata)
                                         && $stable(sbr.rid) && $stable(sbr.err)));
endmodule

// File: tb/tb_obi_sram_shim.sv
// Directed and randomised bench for obi_sram_shim with a 1-cycle SRAM model.
module tb_obi_sram_shim;
    localparam int MAW = 12;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obi_sram_shim_if #(.AddrWidth(32), .DataWidth(32), .IdWidth(8)) bus ();

    logic           mem_req, mem_gnt, mem_we;
    logic [MAW-1:0] mem_addr;
    logic [3:0]     mem_be;
    logic [31:0]    mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    obi_sram_shim #(
        .AddrWidth(32), .DataWidth(32), .IdWidth(8),
        .MemAddrWidth(MAW), .MemLatency(1), .NumOutstanding(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .sbr(bus),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    function automatic logic [31:0] pat(input logic [MAW-1:0] w);
        return 32'hA500_0000 | 32'(w);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // SRAM macro model: unwritten words read back as a recognisable pattern.
    logic [31:0]   sram [1 << MAW];
    bit [4095:0]   written;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written   <= '0;
            mem_rdata <= '0;
        end else if (mem_req && mem_gnt) begin
            if (mem_we) begin
                sram[mem_addr]    <= merge(written[mem_addr] ? sram[mem_addr] : pat(mem_addr),
                                           mem_wdata, mem_be);
                written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr] ? sram[mem_addr] : pat(mem_addr);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.be = '0; bus.wdata = '0; bus.aid = '0;
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [7:0] aid);
        bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.be = 4'hF; bus.wdata = wdata; bus.aid = aid;
    endtask

    task automatic test_reset;
        idle();
        bus.rready = 1'b1;
        mem_gnt    = 1'b1;
        #2;
        checks++; if ({bus.rvalid, bus.rid, bus.rdata, bus.err} !== 42'd0) begin errors++;
            $display("FAIL reset_outputs: got rv=%b rid=%h rdata=%h err=%b want all 0",
                     bus.rvalid, bus.rid, bus.rdata, bus.err); end
        checks++; if (bus.gnt !== 1'b0) begin errors++;
            $display("FAIL reset_gnt: got %b want 0", bus.gnt); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        tick(); drive(1'b1, 32'h0000_1100, 32'hDEADBEEF, 8'd3); #2;
        checks++; if ({bus.gnt, mem_req, mem_we, mem_addr} !== {3'b111, 12'h440}) begin errors++;
            $display("FAIL wr_issue: got gnt=%b req=%b we=%b addr=%h want 1 1 1 440",
                     bus.gnt, mem_req, mem_we, mem_addr); end
        tick(); drive(1'b0, 32'h0000_1100, 32'h0, 8'd4); #2;
        checks++; if (bus.gnt !== 1'b1) begin errors++;
            $display("FAIL rd_gnt: got %b want 1", bus.gnt); end
        checks++; if ({bus.rvalid, bus.rid, bus.rdata, bus.err} !== {1'b1, 8'd3, 32'h0, 1'b0}) begin errors++;
            $display("FAIL wr_rsp: got rv=%b rid=%h rdata=%h err=%b want 1 03 00000000 0",
                     bus.rvalid, bus.rid, bus.rdata, bus.err); end
        tick(); idle(); #2;
        checks++; if ({bus.rvalid, bus.rid, bus.rdata, bus.err} !== {1'b1, 8'd4, 32'hDEADBEEF, 1'b0}) begin errors++;
            $display("FAIL rd_rsp: got rv=%b rid=%h rdata=%h err=%b want 1 04 deadbeef 0",
                     bus.rvalid, bus.rid, bus.rdata, bus.err); end
        tick(); #2;
        checks++; if (bus.rvalid !== 1'b0) begin errors++;
            $display("FAIL wr_rd_idle: got rvalid=%b want 0", bus.rvalid); end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 6; k++) begin
            tick(); drive(1'b0, 32'(k * 4), 32'h0, 8'(8'h10 + k)); #2;
            checks++; if (bus.gnt !== 1'b1) begin errors++;
                $display("FAIL b2b_gnt[%0d]: got %b want 1", k, bus.gnt); end
            if (k > 0) begin
                checks++; if ({bus.rvalid, bus.rid, bus.rdata} !== {1'b1, 8'(8'h10 + k - 1), pat(MAW'(k - 1))}) begin
                    errors++; $display("FAIL b2b_rsp[%0d]: got rv=%b rid=%h rdata=%h want 1 %h %h",
                        k, bus.rvalid, bus.rid, bus.rdata, 8'(8'h10 + k - 1), pat(MAW'(k - 1))); end
            end
        end
        tick(); idle(); #2;
        checks++; if ({bus.rvalid, bus.rid, bus.rdata} !== {1'b1, 8'h15, pat(MAW'(5))}) begin errors++;
            $display("FAIL b2b_last: got rv=%b rid=%h rdata=%h want 1 15 %h",
                     bus.rvalid, bus.rid, bus.rdata, pat(MAW'(5))); end
        tick(); #2;
        checks++; if (bus.rvalid !== 1'b0) begin errors++;
            $display("FAIL b2b_idle: got rvalid=%b want 0", bus.rvalid); end
    endtask

    task automatic test_backpressure;
        logic [3:0]  gnt_exp [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0]  rid_exp [6] = '{8'h00, 8'h20, 8'h20, 8'h20, 8'h20, 8'h21};
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) bus.rready = 1'b0;
            if (c == 4) bus.rready = 1'b1;
            if (c < 3) drive(1'b0, 32'(32 + 4 * c), 32'h0, 8'(8'h20 + c));
            #2;
            checks++; if (bus.gnt !== gnt_exp[c][0]) begin errors++;
                $display("FAIL bp_gnt[%0d]: got %b want %b", c, bus.gnt, gnt_exp[c][0]); end
            if (c > 0) begin
                checks++; if ({bus.rvalid, bus.rid, bus.rdata} !== {1'b1, rid_exp[c], pat(MAW'(rid_exp[c] - 8'h18))}) begin
                    errors++; $display("FAIL bp_rsp[%0d]: got rv=%b rid=%h rdata=%h want 1 %h %h", c,
                        bus.rvalid, bus.rid, bus.rdata, rid_exp[c], pat(MAW'(rid_exp[c] - 8'h18))); end
            end
        end
        tick(); idle(); #2;
        checks++; if ({bus.rvalid, bus.rid, bus.rdata} !== {1'b1, 8'h22, pat(MAW'(10))}) begin errors++;
            $display("FAIL bp_third: got rv=%b rid=%h rdata=%h want 1 22 %h",
                     bus.rvalid, bus.rid, bus.rdata, pat(MAW'(10))); end
        tick(); #2;
        checks++; if (bus.rvalid !== 1'b0) begin errors++;
            $display("FAIL bp_idle: got rvalid=%b want 0", bus.rvalid); end
    endtask

    task automatic test_oor;
        tick(); drive(1'b0, 32'h0000_4000, 32'h0, 8'h30); #2;
        checks++; if ({bus.gnt, mem_req} !== 2'b10) begin errors++;
            $display("FAIL oor_issue: got gnt=%b mem_req=%b want 1 0", bus.gnt, mem_req); end
        tick(); drive(1'b0, 32'h0000_3FFC, 32'h0, 8'h31); #2;
        checks++; if ({bus.gnt, mem_req, mem_addr} !== {2'b11, 12'hFFF}) begin errors++;
            $display("FAIL top_issue: got gnt=%b mem_req=%b addr=%h want 1 1 fff", bus.gnt, mem_req, mem_addr); end
        checks++; if ({bus.rvalid, bus.rid, bus.rdata, bus.err} !== {1'b1, 8'h30, 32'h0, 1'b1}) begin errors++;
            $display("FAIL oor_rsp: got rv=%b rid=%h rdata=%h err=%b want 1 30 00000000 1",
                     bus.rvalid, bus.rid, bus.rdata, bus.err); end
        tick(); idle(); #2;
        checks++; if ({bus.rvalid, bus.rid, bus.rdata, bus.err} !== {1'b1, 8'h31, pat(12'hFFF), 1'b0}) begin errors++;
            $display("FAIL top_rsp: got rv=%b rid=%h rdata=%h err=%b want 1 31 %h 0",
                     bus.rvalid, bus.rid, bus.rdata, bus.err, pat(12'hFFF)); end
    endtask

    task automatic test_mem_stall;
        mem_gnt = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(); drive(1'b0, 32'd20, 32'h0, 8'h40); #2;
            checks++; if ({bus.gnt, mem_req, bus.rvalid} !== 3'b010) begin errors++;
                $display("FAIL stall[%0d]: got gnt=%b mem_req=%b rvalid=%b want 0 1 0",
                         c, bus.gnt, mem_req, bus.rvalid); end
        end
        tick(); mem_gnt = 1'b1; #2;
        checks++; if (bus.gnt !== 1'b1) begin errors++;
            $display("FAIL stall_release_gnt: got %b want 1", bus.gnt); end
        tick(); idle(); #2;
        checks++; if ({bus.rvalid, bus.rid, bus.rdata} !== {1'b1, 8'h40, pat(MAW'(5))}) begin errors++;
            $display("FAIL stall_rsp: got rv=%b rid=%h rdata=%h want 1 40 %h",
                     bus.rvalid, bus.rid, bus.rdata, pat(MAW'(5))); end
        tick(); #2;
        checks++; if (bus.rvalid !== 1'b0) begin errors++;
            $display("FAIL stall_idle: got rvalid=%b want 0", bus.rvalid); end
    endtask

    task automatic test_reset_midflight;
        tick(); bus.rready = 1'b0; drive(1'b0, 32'd4, 32'h0, 8'h50);
        tick(); drive(1'b0, 32'd8, 32'h0, 8'h51);
        tick(); idle(); #2;
        checks++; if ({bus.rvalid, bus.rid} !== {1'b1, 8'h50}) begin errors++;
            $display("FAIL mid_pending: got rv=%b rid=%h want 1 50", bus.rvalid, bus.rid); end
        rst_n = 1'b0; #1;
        checks++; if ({bus.rvalid, bus.rid, bus.rdata, bus.err} !== 42'd0) begin errors++;
            $display("FAIL mid_reset: got rv=%b rid=%h rdata=%h err=%b want all 0",
                     bus.rvalid, bus.rid, bus.rdata, bus.err); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; #2;
        checks++; if (bus.rvalid !== 1'b0) begin errors++;
            $display("FAIL mid_stale: got rvalid=%b want 0", bus.rvalid); end
        for (int c = 0; c < 3; c++) begin
            tick(); drive(1'b0, 32'(12 + 4 * c), 32'h0, 8'(8'h52 + c)); #2;
            checks++; if (bus.gnt !== (c < 2)) begin errors++;
                $display("FAIL mid_credit[%0d]: got gnt=%b want %b", c, bus.gnt, c < 2); end
        end
        for (int c = 0; c < 2; c++) begin
            tick(); idle(); bus.rready = 1'b1; #2;
            checks++; if ({bus.rvalid, bus.rid, bus.rdata} !== {1'b1, 8'(8'h52 + c), pat(MAW'(3 + c))}) begin
                errors++; $display("FAIL mid_drain[%0d]: got rv=%b rid=%h rdata=%h want 1 %h %h", c,
                    bus.rvalid, bus.rid, bus.rdata, 8'(8'h52 + c), pat(MAW'(3 + c))); end
        end
        tick(); #2;
        checks++; if (bus.rvalid !== 1'b0) begin errors++;
            $display("FAIL mid_idle: got rvalid=%b want 0", bus.rvalid); end
    endtask

    task automatic test_random;
        exp_t        q[$];
        exp_t        e, got;
        logic [31:0] shadow [16];
        bit [15:0]   sh_wr = '0;
        logic [3:0]  w;
        logic        is_oor;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (c < 360) begin
                w        = 4'($urandom_range(0, 15));
                is_oor   = ($urandom_range(0, 7) == 0);
                bus.req  = ($urandom_range(0, 3) != 0);
                bus.we   = 1'($urandom);
                bus.addr = (is_oor ? 32'h0001_0000 : 32'h0) | 32'({w, 2'b00});
                bus.be   = 4'($urandom_range(1, 15));
                bus.wdata = $urandom;
                bus.aid  = 8'($urandom);
                bus.rready = ($urandom_range(0, 3) != 0);
                mem_gnt  = ($urandom_range(0, 3) != 0);
            end else begin
                idle(); bus.rready = 1'b1; mem_gnt = 1'b1;
            end
            #2;
            if (bus.rvalid && bus.rready) begin
                got = '{id: bus.rid, rdata: bus.rdata, err: bus.err};
                checks++;
                if (q.size() == 0) begin errors++;
                    $display("FAIL rnd_unexpected[%0d]: got rid=%h with no response outstanding", c, bus.rid);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin errors++;
                        $display("FAIL rnd_rsp[%0d]: got rid=%h rdata=%h err=%b want rid=%h rdata=%h err=%b",
                                 c, got.id, got.rdata, got.err, e.id, e.rdata, e.err); end
                end
            end
            if (bus.gnt) begin
                if (bus.addr[16]) begin
                    e = '{id: bus.aid, rdata: 32'h0, err: 1'b1};
                end else if (bus.we) begin
                    shadow[w] = merge(sh_wr[w] ? shadow[w] : pat(MAW'(w)), bus.wdata, bus.be);
                    sh_wr[w]  = 1'b1;
                    e = '{id: bus.aid, rdata: 32'h0, err: 1'b0};
                end else begin
                    e = '{id: bus.aid, rdata: sh_wr[w] ? shadow[w] : pat(MAW'(w)), err: 1'b0};
                end
                q.push_back(e);
            end
        end
        checks++; if (q.size() != 0 || bus.rvalid !== 1'b0) begin errors++;
            $display("FAIL rnd_drain: got %0d responses missing, rvalid=%b want 0 and 0", q.size(), bus.rvalid); end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_oor();
        test_mem_stall();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
